// File: rtl/centroid_tracker_ctrl.sv
// Bright-pixel centroid tracker: accumulates in a 256x256 window, divides at frame end,
// publishes the centroid. Optional CENTROID_HOLD_EN keeps the last result on an empty frame.
module centroid_tracker_ctrl #(
  parameter logic [12:0] H_START   = 13'd0,
  parameter logic [12:0] V_START   = 13'd0,
  parameter logic [9:0]  THRESH    = 10'd800,
  parameter logic [16:0] MIN_COUNT = 17'd16
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iDVAL,
  input  logic [12:0] iXposition,
  input  logic [12:0] iYposition,
  input  logic [9:0]  iGray,
  input  logic        iFrameEnd,
  output logic [12:0] oXresult,
  output logic [12:0] oYresult,
  output logic        oFinished,
  output logic        oBusy
);

  localparam logic [1:0] ST_ACCUM   = 2'd0;
  localparam logic [1:0] ST_DIV_X   = 2'd1;
  localparam logic [1:0] ST_DIV_Y   = 2'd2;
  localparam logic [1:0] ST_PUBLISH = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [23:0] sum_x_q, sum_x_d;
  logic [23:0] sum_y_q, sum_y_d;
  logic [16:0] count_q, count_d;
  logic [23:0] dvd_q, dvd_d;
  logic [17:0] rem_q, rem_d;
  logic [4:0]  step_q, step_d;
  logic [7:0]  quot_x_q, quot_x_d;
  logic [12:0] x_res_q, x_res_d;
  logic [12:0] y_res_q, y_res_d;
  logic        fin_q, fin_d;

  // Window bounds compared in 14 bits so START+256 cannot wrap.
  logic [13:0] x_ext, y_ext, h_lo, v_lo;
  logic        in_x, in_y, pix_ok;
  logic [7:0]  x_off, y_off;
  logic [23:0] sum_x_acc, sum_y_acc;
  logic [16:0] count_acc;

  assign x_ext  = {1'b0, iXposition};
  assign y_ext  = {1'b0, iYposition};
  assign h_lo   = {1'b0, H_START};
  assign v_lo   = {1'b0, V_START};
  assign in_x   = (x_ext >= h_lo) && (x_ext < h_lo + 14'd256);
  assign in_y   = (y_ext >= v_lo) && (y_ext < v_lo + 14'd256);
  assign pix_ok = iDVAL && in_x && in_y && (iGray >= THRESH);
  assign x_off  = iXposition[7:0] - H_START[7:0];
  assign y_off  = iYposition[7:0] - V_START[7:0];

  assign sum_x_acc = pix_ok ? sum_x_q + {16'd0, x_off} : sum_x_q;
  assign sum_y_acc = pix_ok ? sum_y_q + {16'd0, y_off} : sum_y_q;
  assign count_acc = count_q + 17'(pix_ok);

  // One restoring-division step: dividend shifts out MSB first, quotient bits shift in.
  logic [17:0] rem_shift, rem_next;
  logic        rem_ge;
  logic [23:0] dvd_next;
  logic        last_step;

  assign rem_shift = {rem_q[16:0], dvd_q[23]};
  assign rem_ge    = rem_shift >= {1'b0, count_q};
  assign rem_next  = rem_ge ? rem_shift - {1'b0, count_q} : rem_shift;
  assign dvd_next  = {dvd_q[22:0], rem_ge};
  assign last_step = (step_q == 5'd23);

  always_comb begin
    state_d  = state_q;
    sum_x_d  = sum_x_q;
    sum_y_d  = sum_y_q;
    count_d  = count_q;
    dvd_d    = dvd_q;
    rem_d    = rem_q;
    step_d   = step_q;
    quot_x_d = quot_x_q;
    x_res_d  = x_res_q;
    y_res_d  = y_res_q;
    fin_d    = fin_q;
    case (state_q)
      ST_ACCUM: begin
        sum_x_d = sum_x_acc;
        sum_y_d = sum_y_acc;
        count_d = count_acc;
        if (iFrameEnd) begin
          if (count_acc >= MIN_COUNT) begin
            state_d = ST_DIV_X;
            dvd_d   = sum_x_acc;
            rem_d   = 18'd0;
            step_d  = 5'd0;
          end else begin
            sum_x_d = 24'd0;
            sum_y_d = 24'd0;
            count_d = 17'd0;
`ifndef CENTROID_HOLD_EN
            fin_d   = 1'b0;
`endif
          end
        end
      end
      ST_DIV_X: begin
        dvd_d  = dvd_next;
        rem_d  = rem_next;
        step_d = step_q + 5'd1;
        if (last_step) begin
          quot_x_d = dvd_next[7:0];
          dvd_d    = sum_y_q;
          rem_d    = 18'd0;
          step_d   = 5'd0;
          state_d  = ST_DIV_Y;
        end
      end
      ST_DIV_Y: begin
        dvd_d  = dvd_next;
        rem_d  = rem_next;
        step_d = step_q + 5'd1;
        if (last_step) state_d = ST_PUBLISH;
      end
      ST_PUBLISH: begin
        x_res_d = {5'd0, quot_x_q};
        y_res_d = {5'd0, dvd_q[7:0]};
        fin_d   = 1'b1;
        sum_x_d = 24'd0;
        sum_y_d = 24'd0;
        count_d = 17'd0;
        state_d = ST_ACCUM;
      end
      default: state_d = ST_ACCUM;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state_q  <= ST_ACCUM;
      sum_x_q  <= 24'd0;
      sum_y_q  <= 24'd0;
      count_q  <= 17'd0;
      dvd_q    <= 24'd0;
      rem_q    <= 18'd0;
      step_q   <= 5'd0;
      quot_x_q <= 8'd0;
      x_res_q  <= 13'd0;
      y_res_q  <= 13'd0;
      fin_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sum_x_q  <= sum_x_d;
      sum_y_q  <= sum_y_d;
      count_q  <= count_d;
      dvd_q    <= dvd_d;
      rem_q    <= rem_d;
      step_q   <= step_d;
      quot_x_q <= quot_x_d;
      x_res_q  <= x_res_d;
      y_res_q  <= y_res_d;
      fin_q    <= fin_d;
    end
  end

  assign oXresult  = x_res_q;
  assign oYresult  = y_res_q;
  assign oFinished = fin_q;
  assign oBusy     = (state_q != ST_ACCUM);

endmodule

// File: tb/tb_centroid_tracker_ctrl.sv
// Directed/randomized bench for centroid_tracker_ctrl; reference keeps plain integer sums per frame.
// Honours CENTROID_HOLD_EN the same way the design does.
module tb_centroid_tracker_ctrl;

  localparam int H    = 100;
  localparam int V    = 50;
  localparam int MINC = 16;

  logic        iCLK = 1'b0;
  logic        iRST;
  logic        iDVAL;
  logic [12:0] iXposition;
  logic [12:0] iYposition;
  logic [9:0]  iGray;
  logic        iFrameEnd;
  logic [12:0] oXresult;
  logic [12:0] oYresult;
  logic        oFinished;
  logic        oBusy;

  always #5 iCLK = ~iCLK;

  centroid_tracker_ctrl #(
    .H_START  (13'd100),
    .V_START  (13'd50),
    .THRESH   (10'd800),
    .MIN_COUNT(17'd16)
  ) dut (
    .iCLK      (iCLK),
    .iRST      (iRST),
    .iDVAL     (iDVAL),
    .iXposition(iXposition),
    .iYposition(iYposition),
    .iGray     (iGray),
    .iFrameEnd (iFrameEnd),
    .oXresult  (oXresult),
    .oYresult  (oYresult),
    .oFinished (oFinished),
    .oBusy     (oBusy)
  );

  int total = 0;
  int fails = 0;

  // Reference model: running sums of window-relative coordinates for the open frame.
  int mx = 0, my = 0, mc = 0;
  logic [31:0] ex = 0, ey = 0, ef = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic dv, input int x, input int y, input int g, input logic fe);
    iDVAL      = dv;
    iXposition = x[12:0];
    iYposition = y[12:0];
    iGray      = g[9:0];
    iFrameEnd  = fe;
  endtask

  task automatic model_add(input logic dv, input int x, input int y, input int g);
    if (dv && x >= H && x < H + 256 && y >= V && y < V + 256 && g >= 800) begin
      mx += x - H;
      my += y - V;
      mc++;
    end
  endtask

  task automatic pix(input logic dv, input int x, input int y, input int g);
    @(negedge iCLK);
    drive(dv, x, y, g, 1'b0);
    model_add(dv, x, y, g);
  endtask

  task automatic bright_w(input int wx, input int wy);
    pix(1'b1, H + wx, V + wy, int'($urandom_range(1023, 800)));
  endtask

  task automatic rand_frame();
    int n;
    n = int'($urandom_range(40, 16));
    for (int i = 0; i < n; i++) begin
      bright_w(int'($urandom_range(255, 0)), int'($urandom_range(255, 0)));
      case ($urandom_range(4, 0))
        0: pix(1'b1, H + int'($urandom_range(255, 0)), V + 3, int'($urandom_range(799, 0)));
        1: pix(1'b1, H + 256 + int'($urandom_range(50, 0)), V + 5, 900);
        2: pix(1'b1, H - 1 - int'($urandom_range(50, 0)), V + 5, 900);
        3: pix(1'b1, H + 5, V - 1 - int'($urandom_range(40, 0)), 900);
        default: pix(1'b0, H + 20, V + 20, 1000);
      endcase
    end
  endtask

  // Pulses iFrameEnd and follows the frame to its result (or no-result path).
  task automatic close_frame(input bit inject, input bit edge_pix);
    logic [31:0] nx, ny;
    @(negedge iCLK);
    drive(1'b0, 0, 0, 0, 1'b1);
    if (mc >= MINC) begin
      nx = 32'(mx / mc);
      ny = 32'(my / mc);
      mx = 0; my = 0; mc = 0;
      for (int j = 1; j <= 50; j++) begin
        @(negedge iCLK);
        drive(1'b0, 0, 0, 0, 1'b0);
        if (inject && j >= 26 && j <= 40)
          drive(1'b1, H + int'($urandom_range(255, 0)), V + int'($urandom_range(255, 0)), 1000, j == 32);
        check("busy", 32'(oBusy), 32'(j <= 49));
        if (j == 1 || j == 49) begin
          check("x_held_mid", 32'(oXresult), ex);
          check("fin_held_mid", 32'(oFinished), ef);
        end
        if (j == 50) begin
          ex = nx; ey = ny; ef = 1;
          check("x_result", 32'(oXresult), ex);
          check("y_result", 32'(oYresult), ey);
          check("finished", 32'(oFinished), ef);
          if (edge_pix) begin
            drive(1'b1, H + 7, V + 9, 900, 1'b0);
            model_add(1'b1, H + 7, V + 9, 900);
          end
        end
      end
    end else begin
      mx = 0; my = 0; mc = 0;
      @(negedge iCLK);
      drive(1'b0, 0, 0, 0, 1'b0);
`ifndef CENTROID_HOLD_EN
      ef = 0;
`endif
      check("nores_busy", 32'(oBusy), 32'd0);
      check("nores_fin", 32'(oFinished), ef);
      check("nores_x", 32'(oXresult), ex);
      check("nores_y", 32'(oYresult), ey);
    end
  endtask

  initial begin
    iRST = 1'b0;
    drive(1'b0, 0, 0, 0, 1'b0);
    repeat (3) @(negedge iCLK);
    check("rst_x", 32'(oXresult), 32'd0);
    check("rst_y", 32'(oYresult), 32'd0);
    check("rst_fin", 32'(oFinished), 32'd0);
    check("rst_busy", 32'(oBusy), 32'd0);
    iRST = 1'b1;

    // Sixteen pixels at one window point.
    for (int i = 0; i < 16; i++) bright_w(40, 200);
    close_frame(1'b0, 1'b0);

    // Truncated average 23/2, with a pixel counted on the first ACCUM edge after publish.
    for (int i = 0; i < 8; i++) bright_w(10, 100);
    for (int i = 0; i < 8; i++) bright_w(13, 100);
    close_frame(1'b0, 1'b1);

    // Window edges and threshold: none of the extras may count.
    for (int i = 0; i < 16; i++) bright_w(50, 60);
    pix(1'b1, H + 256, V + 60, 900);
    pix(1'b1, H - 1, V + 60, 900);
    pix(1'b1, H + 50, V - 1, 900);
    pix(1'b1, H + 50, V + 256, 900);
    pix(1'b1, H + 255, V + 255, 799);
    pix(1'b0, H + 200, V + 200, 900);
    close_frame(1'b0, 1'b0);

    // Too few pixels.
    for (int i = 0; i < 5; i++) bright_w(int'($urandom_range(255, 0)), 30);
    close_frame(1'b0, 1'b0);

    // Frame end and pixels during division are dropped; next frame starts clean.
    for (int i = 0; i < 20; i++) bright_w(int'($urandom_range(255, 0)), int'($urandom_range(255, 0)));
    close_frame(1'b1, 1'b0);
    rand_frame();
    close_frame(1'b0, 1'b0);

    // Reset in the middle of the division.
    for (int i = 0; i < 20; i++) bright_w(int'($urandom_range(255, 0)), int'($urandom_range(255, 0)));
    @(negedge iCLK);
    drive(1'b0, 0, 0, 0, 1'b1);
    for (int j = 1; j <= 30; j++) begin
      @(negedge iCLK);
      drive(1'b0, 0, 0, 0, 1'b0);
    end
    #2 iRST = 1'b0;
    #1;
    mx = 0; my = 0; mc = 0;
    ex = 0; ey = 0; ef = 0;
    check("abort_x", 32'(oXresult), ex);
    check("abort_y", 32'(oYresult), ey);
    check("abort_fin", 32'(oFinished), ef);
    check("abort_busy", 32'(oBusy), 32'd0);
    @(negedge iCLK);
    iRST = 1'b1;
    rand_frame();
    close_frame(1'b0, 1'b0);

    for (int f = 0; f < 3; f++) begin
      rand_frame();
      close_frame(1'b0, 1'b0);
    end

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
